// File: rtl/led_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : led_seq_ctrl
// Purpose  : 4-LED active-low pattern sequencer (forward/reverse/ping-pong/
//            blink) with programmable step rate, pause and stop.
// Options  : define LED_SEQ_PINGPONG_EN to build the ping-pong mode; without
//            it, mode 2'b10 runs the forward sequence.
// Revision : 1.0 - initial release
// ============================================================================
module led_seq_ctrl #(
  parameter int DIV_BASE = 12500000,
  parameter int CNT_W    = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic [1:0] mode,
  input  logic [1:0] speed,
  output logic [3:0] led,
  output logic       busy,
  output logic       step
);

  localparam logic [3:0]       c_LED_OFF   = 4'b1111;
  localparam logic [3:0]       c_LED_LEFT  = 4'b0111;
  localparam logic [3:0]       c_LED_RIGHT = 4'b1110;
  localparam logic [3:0]       c_LED_ALL   = 4'b0000;
  localparam logic [1:0]       c_MODE_FWD  = 2'b00;
  localparam logic [1:0]       c_MODE_REV  = 2'b01;
  localparam logic [1:0]       c_MODE_PP   = 2'b10;
  localparam logic [1:0]       c_MODE_BLK  = 2'b11;
  localparam logic [CNT_W-1:0] c_DIV       = CNT_W'(DIV_BASE);
  localparam logic [CNT_W-1:0] c_ONE       = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_mode;

  logic [CNT_W-1:0] w_shifted;
  logic [CNT_W-1:0] w_limit;
  logic             w_at_limit;
  logic [3:0]       w_rot_r;
  logic [3:0]       w_rot_l;
  logic [3:0]       w_pp_led;
  logic [3:0]       w_next_led;
  logic [3:0]       w_first_led;

  // Terminal count is P-1 with P = max(1, DIV_BASE >> speed), re-evaluated
  // every cycle so a speed change takes effect immediately.
  assign w_shifted  = c_DIV >> speed;
  assign w_limit    = (w_shifted == '0) ? '0 : (w_shifted - c_ONE);
  assign w_at_limit = (r_cnt >= w_limit);

  assign w_rot_r = {led[0], led[3:1]};
  assign w_rot_l = {led[2:0], led[3]};

`ifdef LED_SEQ_PINGPONG_EN
  logic r_dir_asc;
  assign w_pp_led = r_dir_asc ? w_rot_l : w_rot_r;
`else
  assign w_pp_led = w_rot_r;
`endif

  always_comb begin
    w_next_led = w_rot_r;
    case (r_mode)
      c_MODE_REV: w_next_led = w_rot_l;
      c_MODE_PP:  w_next_led = w_pp_led;
      c_MODE_BLK: w_next_led = ~led;
      default:    w_next_led = w_rot_r;
    endcase
  end

  always_comb begin
    w_first_led = c_LED_LEFT;
    case (mode)
      c_MODE_REV: w_first_led = c_LED_RIGHT;
      c_MODE_BLK: w_first_led = c_LED_ALL;
      default:    w_first_led = c_LED_LEFT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_mode  <= c_MODE_FWD;
      led     <= c_LED_OFF;
      busy    <= 1'b0;
      step    <= 1'b0;
`ifdef LED_SEQ_PINGPONG_EN
      r_dir_asc <= 1'b0;
`endif
    end else begin
      step <= 1'b0;
      case (r_state)
        S_IDLE: begin
          led   <= c_LED_OFF;
          r_cnt <= '0;
          busy  <= 1'b0;
          if (start && !stop) begin
            r_state <= S_RUN;
            r_mode  <= mode;
            led     <= w_first_led;
            busy    <= 1'b1;
`ifdef LED_SEQ_PINGPONG_EN
            r_dir_asc <= 1'b0;
`endif
          end
        end
        S_RUN, S_HOLD: begin
          if (stop) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            led     <= c_LED_OFF;
            busy    <= 1'b0;
          end else if (pause) begin
            r_state <= S_HOLD;
          end else begin
            // Leaving HOLD counts on the same edge, so progress resumes at once.
            r_state <= S_RUN;
            if (w_at_limit) begin
              r_cnt <= '0;
              led   <= w_next_led;
              step  <= 1'b1;
`ifdef LED_SEQ_PINGPONG_EN
              if (r_mode == c_MODE_PP) begin
                if (w_next_led == c_LED_RIGHT)
                  r_dir_asc <= 1'b1;
                else if (w_next_led == c_LED_LEFT)
                  r_dir_asc <= 1'b0;
              end
`endif
            end else begin
              r_cnt <= r_cnt + c_ONE;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          led     <= c_LED_OFF;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_led_seq_ctrl.sv
`default_nettype none
// Bench for led_seq_ctrl: directed scenarios plus random traffic, checked
// against a pattern-table reference model through a step-event scoreboard.
module tb_led_seq_ctrl;

  localparam int c_DIV = 8;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop  = 1'b0;
  logic       pause = 1'b0;
  logic [1:0] mode  = 2'b00;
  logic [1:0] speed = 2'b00;
  logic [3:0] led;
  logic       busy;
  logic       step;

  led_seq_ctrl #(.DIV_BASE(c_DIV), .CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .stop  (stop),
    .pause (pause),
    .mode  (mode),
    .speed (speed),
    .led   (led),
    .busy  (busy),
    .step  (step)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         stamp;
    logic [3:0] led;
  } ev_t;
  ev_t q[$];

  logic [3:0] c_fwd [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
  logic [3:0] c_rev [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [3:0] c_pp  [6] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110, 4'b1101, 4'b1011};

  // Reference model: sequence position plus cycles elapsed since last advance.
  bit         m_busy    = 1'b0;
  logic [1:0] m_mode    = 2'b00;
  int         m_idx     = 0;
  int         m_elapsed = 0;

  function automatic logic [3:0] pattern(input logic [1:0] md, input int idx);
    case (md)
      2'b01:   return c_rev[idx % 4];
      2'b11:   return ((idx % 2) == 0) ? 4'b0000 : 4'b1111;
`ifdef LED_SEQ_PINGPONG_EN
      2'b10:   return c_pp[idx % 6];
`endif
      default: return c_fwd[idx % 4];
    endcase
  endfunction

  function automatic logic [3:0] exp_led();
    return m_busy ? pattern(m_mode, m_idx) : 4'b1111;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_busy    = 1'b0;
    m_idx     = 0;
    m_elapsed = 0;
    q.delete();
  endtask

  task automatic model_edge();
    int   p;
    ev_t  e;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (!m_busy) begin
      if (start && !stop) begin
        m_busy    = 1'b1;
        m_mode    = mode;
        m_idx     = 0;
        m_elapsed = 0;
      end
    end else if (stop) begin
      m_busy = 1'b0;
    end else if (!pause) begin
      p = c_DIV >> speed;
      if (p < 1) p = 1;
      if (m_elapsed >= p - 1) begin
        m_elapsed = 0;
        m_idx++;
        e.stamp = cyc;
        e.led   = pattern(m_mode, m_idx);
        q.push_back(e);
      end else begin
        m_elapsed++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
  endtask

  // Monitor: every step pulse must match the head of the scoreboard queue.
  always @(negedge clk) begin
    bit  exp_step;
    ev_t e;
    exp_step = (q.size() > 0) && (q[0].stamp == cyc);
    check("step", 32'(step), 32'(exp_step));
    if (exp_step) begin
      e = q.pop_front();
      check("step_led", 32'(led), 32'(e.led));
    end
    check("led", 32'(led), 32'(exp_led()));
    check("busy", 32'(busy), 32'(m_busy));
  end

  initial begin
    int n;
    bit found;

    repeat (2) tick();
    check("rst_led", 32'(led), 32'hF);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_step", 32'(step), 32'h0);
    rst_n = 1'b1;
    tick();

    // Forward at speed 0
    mode = 2'b00; speed = 2'b00; start = 1'b1;
    tick();
    start = 1'b0;
    check("first_fwd", 32'(led), 32'h7);
    repeat (40) tick();

    // start+stop together in RUN, then in IDLE
    start = 1'b1; stop = 1'b1;
    tick();
    check("stop_prio_busy", 32'(busy), 32'h0);
    check("stop_prio_led", 32'(led), 32'hF);
    tick();
    check("idle_pair_busy", 32'(busy), 32'h0);
    start = 1'b0; stop = 1'b0;
    tick();

    // Ping-pong at P=2; later mode changes must be ignored
    mode = 2'b10; speed = 2'b10; start = 1'b1;
    tick();
    start = 1'b0; mode = 2'b01;
    repeat (30) tick();
    stop = 1'b1; tick(); stop = 1'b0;

    // Pause at cnt=3 for 10 cycles
    mode = 2'b00; speed = 2'b00; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    pause = 1'b1;
    repeat (10) tick();
    check("hold_led", 32'(led), 32'h7);
    check("hold_busy", 32'(busy), 32'h1);
    pause = 1'b0;
    tick();
    n = 0; found = 1'b0;
    for (int i = 1; i <= 12 && !found; i++) begin
      tick();
      if (step) begin found = 1'b1; n = i; end
    end
    check("resume_gap", 32'(n), 32'd4);
    stop = 1'b1; tick(); stop = 1'b0;

    // Speed change 0 -> 3 at cnt=5
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    speed = 2'b11;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("fast_step", 32'(step), 32'h1);
    end
    speed = 2'b00;
    stop = 1'b1; tick(); stop = 1'b0;

    // Asynchronous reset mid-run with led=1101
    speed = 2'b01; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    check("pre_rst_led", 32'(led), 32'hD);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_led", 32'(led), 32'hF);
    check("async_rst_busy", 32'(busy), 32'h0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("post_rst_idle", 32'(busy), 32'h0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 19) == 0);
      stop  = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 7) == 0) pause = ~pause;
      mode = 2'($urandom);
      if ($urandom_range(0, 29) == 0) speed = 2'($urandom);
      tick();
    end
    start = 1'b0; stop = 1'b0; pause = 1'b0;
    repeat (3) tick();
    check("queue_drained", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/led_seq_ctrl.md
LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-002 Parameter DIV_BASE SHALL default to 12500000 and SHALL set the clk cycles per LED step at speed 0.
REQ-003 Parameter CNT_W SHALL default to 32 and SHALL set the step-counter width.
REQ-004 Port clk SHALL be an input, 1 bit: system clock, rising edge.
REQ-005 Port rst_n SHALL be an input, 1 bit: asynchronous active-low reset.
REQ-006 Port start SHALL be an input, 1 bit: one-cycle request to begin a sequence.
REQ-007 Port stop SHALL be an input, 1 bit: one-cycle request to abort and blank the LEDs.
REQ-008 Port pause SHALL be an input, 1 bit: level; freezes the sequence while high.
REQ-009 Port mode SHALL be an input, 2 bits: 00 forward, 01 reverse, 10 ping-pong, 11 blink.
REQ-010 Port speed SHALL be an input, 2 bits: step period P = max(1, DIV_BASE >> speed).
REQ-011 Port led SHALL be an output register, 4 bits, active-low: 0 means lit.
REQ-012 Port busy SHALL be an output register, 1 bit: high in RUN and HOLD.
REQ-013 Port step SHALL be an output register, 1 bit: one-cycle pulse on each pattern advance.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and HOLD.
REQ-015 In IDLE with start=1 and stop=0, the block SHALL at the next edge latch mode into mode_q, load the first pattern, clear cnt and enter RUN; busy SHALL be 1 from that edge.
REQ-016 First patterns SHALL be: forward 0111; reverse 1110; ping-pong 0111; blink 0000.
REQ-017 Forward SHALL cycle 0111->1011->1101->1110->0111, wrapping.
REQ-018 Reverse SHALL cycle 1110->1101->1011->0111->1110, wrapping.
REQ-019 Ping-pong SHALL cycle 0111->1011->1101->1110->1101->1011->0111, period 6, with a direction flag that reverses at both end positions; the end LEDs SHALL NOT repeat.
REQ-020 Blink SHALL alternate 0000 and 1111.
REQ-021 In RUN, cnt SHALL increment each cycle; when cnt >= P-1, cnt SHALL clear, led SHALL advance one pattern and step SHALL pulse high for exactly one cycle.
REQ-022 P SHALL be recomputed every cycle from speed; a change to a shorter P with cnt already >= P-1 SHALL cause a step on the next edge.
REQ-023 mode changes after start SHALL be ignored until the next start from IDLE.
REQ-024 In RUN with pause=1, the block SHALL enter HOLD at the next edge; HOLD SHALL freeze cnt and led and keep step at 0.
REQ-025 In HOLD with pause=0, the block SHALL return to RUN and resume counting from the frozen cnt.
REQ-026 stop=1 in RUN or HOLD SHALL, at the next edge, enter IDLE with led=1111, cnt=0, busy=0 and step=0.
REQ-027 stop SHALL have priority over start and pause in the same cycle; start in RUN or HOLD SHALL be ignored.
REQ-028 In IDLE, led SHALL hold 1111 and step SHALL be 0.

Reset
REQ-029 rst_n=0 SHALL immediately, without a clock, force state=IDLE, led=1111, cnt=0, busy=0, step=0, mode_q=00 and the direction flag to descending.
REQ-030 Reset asserted mid-sequence SHALL discard all progress; after release, start SHALL be required to run again.

Configuration
REQ-031 Macro LED_SEQ_PINGPONG_EN SHALL, when defined, compile in ping-pong mode and its direction flag.
REQ-032 When LED_SEQ_PINGPONG_EN is undefined, mode 10 SHALL behave exactly as forward (00) and the direction flag SHALL NOT be implemented.

Verification (DIV_BASE=8)
REQ-033 Reset then start with mode=00 and speed=0: led SHALL be 0111 one edge later, then 1011, 1101, 1110, 0111 at 8-cycle intervals, with step high for 1 cycle at each change.
REQ-034 mode=10 and speed=2 (P=2), with LED_SEQ_PINGPONG_EN defined: led SHALL follow 0111, 1011, 1101, 1110, 1101, 1011, 0111 every 2 cycles; with the macro undefined, led SHALL follow the forward sequence.
REQ-035 Raise pause at cnt=3 for 10 cycles, then release: led SHALL be unchanged throughout, busy SHALL stay 1, and the next step SHALL occur 4 cycles after release.
REQ-036 Assert start and stop in the same RUN cycle: next edge SHALL give IDLE, led=1111, busy=0; the same pair in IDLE SHALL leave the block in IDLE.
REQ-037 Change speed from 0 to 3 (P=1) at cnt=5: step SHALL fire on the next edge and then every cycle.
REQ-038 Drop rst_n asynchronously between clock edges during RUN with led=1101: led SHALL read 1111 and busy SHALL read 0 before the next clk edge.
